oled_seq_ctrl: RTL and testbench
================================

// Module: oled_seq_ctrl
// PURPOSE
//  Sequencer/arbiter in front of the OLED SPI byte engine (data_type/byte_count/send_bytes/done interface).
//  Runs the panel power-up (PMODEN, RES, init command list, VCCEN, display-on).
//  Then shares the engine between a command requester and a pixel stream; one transfer in flight at a time.
// PARAMETERS
//  PWR_WAIT_CYC  2_000_000   clk cycles after PMODEN before reset pulse (20 ms @100 MHz)
//  RES_LOW_CYC   300         clk cycles RES held low, and again held high before init
//  VCC_WAIT_CYC  10_000_000  clk cycles after VCCEN before display-on (100 ms)
//  FLUSH_CYC     64          batch idle-flush timeout (OLED_PIX_BATCH_EN only)
// PORTS
//  clk             in   1    system clock (100 MHz)
//  rst_n           in   1    asynchronous, active-low reset
//  start           in   1    pulse: begin power-up; honoured only in OFF
//  cmd_req         in   1    command request; hold until cmd_ack
//  cmd_count       in   4    command bytes, 0..15
//  cmd_bytes       in   120  command bytes, first byte at [119:112]
//  cmd_ack         out  1    1-cycle pulse: command latched
//  pix_valid       in   1    pixel available
//  pix_data        in   16   RGB565 pixel, sent [15:8] then [7:0]
//  pix_last        in   1    last pixel of frame (batch flush hint)
//  pix_ready       out  1    pixel accepted when pix_valid && pix_ready
//  spi_data_type   out  1    0 command, 1 data
//  spi_byte_count  out  4    nonzero for exactly one cycle per transfer (issue strobe)
//  spi_bytes       out  120  payload, MSB-first
//  spi_done        in   1    engine completion pulse
//  oled_pmoden / oled_vccen / oled_res  out 1 each   panel rails / reset (res active-low)
//  ready           out  1    1 once power-up complete
// BEHAVIOUR
//  Reset: spi_byte_count=0, spi_bytes=0, spi_data_type=0, cmd_ack=0, pix_ready=0, ready=0,
//   oled_pmoden=0, oled_vccen=0, oled_res=1, state=OFF. Reset mid-transfer abandons it (engine shares reset).
//  States: OFF -> PWR_WAIT (pmoden=1, PWR_WAIT_CYC) -> RES_LOW (res=0, RES_LOW_CYC) -> RES_HIGH
//   (res=1, RES_LOW_CYC) -> INIT (one command transfer per init-ROM entry, in order) -> VCC_WAIT
//   (vccen=1, VCC_WAIT_CYC) -> DISP_ON (send 0xAF) -> READY <-> ISSUE -> WAIT_DONE -> READY.
//  ISSUE: drive type/bytes and nonzero count for exactly 1 cycle, then count=0 in WAIT_DONE
//   (engine re-arms on nonzero count in its idle state; count must be 0 the cycle done is seen).
//  WAIT_DONE leaves on spi_done only; spi_done in any other state is ignored. No timeout.
//  READY arbitration: cmd_req has strict priority; pix_ready = (state==READY) && !cmd_req.
//  Command: cmd_ack pulses in the ISSUE cycle; cmd_count==0 -> acked, no transfer, back to READY.
//  Pixel (macro off): each accepted pixel -> data transfer, count=2, bytes={pix_data,104'b0}.
//  ready stays 1 once set until reset; start while not OFF ignored.
// CONFIGURATION
//  OLED_PIX_BATCH_EN defined: pixels packed into a 7-pixel (14-byte) buffer, first pixel at [119:112];
//   issue when 7 held, when a pixel with pix_last is accepted, or after FLUSH_CYC cycles with no
//   accept and buffer nonempty. cmd_req with nonempty buffer: flush buffer first, then command.
//   pix_ready low while buffer transfer in flight.
//  Not defined: no buffer, pix_last ignored, one 2-byte transfer per pixel.
// STRUCTURE
//  oled_ctrl_pkg: state enum, INIT_LEN, init ROM (count+bytes per entry), CMD_DISPLAY_ON=8'hAF,
//   CMD_DISPLAY_OFF=8'hAE, PIX_PER_BATCH=7.
//  Sub-module oled_delay_timer: loadable down-counter (load, value, expired) shared by all wait states.
// TESTING (small params: PWR_WAIT=20, RES_LOW=5, VCC_WAIT=30; SPI engine model with 10-cycle done)
//  start pulse -> pmoden at +1, res low exactly 5 cycles, INIT_LEN command transfers, vccen, 0xAF, ready=1.
//  cmd_req count=3 bytes=AA_BB_CC.. -> one ack pulse, spi_byte_count=3 one cycle, data_type=0.
//  cmd_req and pix_valid same cycle -> command first, pixel (0xF800 -> bytes F8,00, type=1) next.
//  cmd_count=0 -> ack, no spi_byte_count strobe; rst_n low during WAIT_DONE -> all outputs at reset values.
//  Batch on: 7 pixels -> one count=14 transfer; 3 pixels+pix_last -> count=6; 2 pixels idle -> flush at FLUSH_CYC.
//  Batch on: 2 pixels buffered then cmd_req -> count=4 data transfer precedes command transfer.

Source files
------------

// File: rtl/oled_ctrl_pkg.sv
// ============================================================================
//  Module   : oled_ctrl_pkg
//  Brief    : Shared types, constants and init-command ROM for the OLED sequencer.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package oled_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_OFF       = 4'd0,
        ST_PWR_WAIT  = 4'd1,
        ST_RES_LOW   = 4'd2,
        ST_RES_HIGH  = 4'd3,
        ST_INIT      = 4'd4,
        ST_VCC_WAIT  = 4'd5,
        ST_DISP_ON   = 4'd6,
        ST_READY     = 4'd7,
        ST_ISSUE     = 4'd8,
        ST_WAIT_DONE = 4'd9
    } state_t;

    localparam int         INIT_LEN        = 4;
    localparam int         INIT_IDX_W      = 3;
    localparam int         TMR_W           = 32;
    localparam int         PIX_PER_BATCH   = 7;
    localparam logic [7:0] CMD_DISPLAY_ON  = 8'hAF;
    localparam logic [7:0] CMD_DISPLAY_OFF = 8'hAE;

    typedef struct packed {
        logic [3:0]   count;
        logic [119:0] bytes;
    } init_entry_t;

    // Panel bring-up list: unlock, display off, remap, column window.
    function automatic init_entry_t init_rom(input logic [INIT_IDX_W-1:0] idx);
        init_entry_t e;
        e.count = 4'd0;
        e.bytes = '0;
        case (idx)
            3'd0: begin e.count = 4'd2; e.bytes = {8'hFD, 8'h12, 104'h0};        end
            3'd1: begin e.count = 4'd1; e.bytes = {CMD_DISPLAY_OFF, 112'h0};     end
            3'd2: begin e.count = 4'd2; e.bytes = {8'hA0, 8'h72, 104'h0};        end
            3'd3: begin e.count = 4'd3; e.bytes = {8'h15, 8'h00, 8'h5F, 96'h0};  end
            default: ;
        endcase
        return e;
    endfunction

endpackage

`default_nettype wire

// File: rtl/oled_delay_timer.sv
// ============================================================================
//  Module   : oled_delay_timer
//  Brief    : Loadable down-counter; expired is high while the count is zero.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module oled_delay_timer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expired
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = value;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/oled_seq_ctrl.sv
// ============================================================================
//  Module   : oled_seq_ctrl
//  Brief    : OLED power-up sequencer and command/pixel arbiter for the SPI
//             byte engine. Define OLED_PIX_BATCH_EN to pack pixels 7 per transfer.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module oled_seq_ctrl
    import oled_ctrl_pkg::*;
#(
    parameter int PWR_WAIT_CYC = 2_000_000,
    parameter int RES_LOW_CYC  = 300,
    parameter int VCC_WAIT_CYC = 10_000_000,
    parameter int FLUSH_CYC    = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         cmd_req,
    input  logic [3:0]   cmd_count,
    input  logic [119:0] cmd_bytes,
    output logic         cmd_ack,
    input  logic         pix_valid,
    input  logic [15:0]  pix_data,
    input  logic         pix_last,
    output logic         pix_ready,
    output logic         spi_data_type,
    output logic [3:0]   spi_byte_count,
    output logic [119:0] spi_bytes,
    input  logic         spi_done,
    output logic         oled_pmoden,
    output logic         oled_vccen,
    output logic         oled_res,
    output logic         ready
);

    state_t                 state_q, state_d;
    logic [INIT_IDX_W-1:0]  init_idx_q, init_idx_d;
    logic                   ready_q, ready_d;
    logic                   xfer_type_q, xfer_type_d;
    logic [3:0]             xfer_cnt_q, xfer_cnt_d;
    logic [119:0]           xfer_bytes_q, xfer_bytes_d;
    logic                   from_cmd_q, from_cmd_d;
    logic                   tmr_load;
    logic [TMR_W-1:0]       tmr_value;
    logic                   tmr_expired;
    init_entry_t            init_ent;
    logic                   pix_accept;

    oled_delay_timer #(.W(TMR_W)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (tmr_load),
        .value   (tmr_value),
        .expired (tmr_expired)
    );

    assign pix_accept = pix_valid && pix_ready;

`ifdef OLED_PIX_BATCH_EN
    localparam int IDLE_W = $clog2(FLUSH_CYC + 1);

    logic [119:0]    buf_q, buf_d;
    logic [2:0]      buf_n_q, buf_n_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic            issue_buf;
    logic [119:0]    buf_src;
    logic [2:0]      buf_cnt;
    logic [119:0]    buf_ins;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q   <= '0;
            buf_n_q <= '0;
            idle_q  <= '0;
        end else begin
            buf_q   <= buf_d;
            buf_n_q <= buf_n_d;
            idle_q  <= idle_d;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = pix_last ^ (FLUSH_CYC == 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_OFF;
            init_idx_q   <= '0;
            ready_q      <= 1'b0;
            xfer_type_q  <= 1'b0;
            xfer_cnt_q   <= 4'd0;
            xfer_bytes_q <= '0;
            from_cmd_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            init_idx_q   <= init_idx_d;
            ready_q      <= ready_d;
            xfer_type_q  <= xfer_type_d;
            xfer_cnt_q   <= xfer_cnt_d;
            xfer_bytes_q <= xfer_bytes_d;
            from_cmd_q   <= from_cmd_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        init_idx_d   = init_idx_q;
        xfer_type_d  = xfer_type_q;
        xfer_cnt_d   = xfer_cnt_q;
        xfer_bytes_d = xfer_bytes_q;
        from_cmd_d   = from_cmd_q;
        tmr_load     = 1'b0;
        tmr_value    = '0;
        init_ent     = init_rom(init_idx_q);
`ifdef OLED_PIX_BATCH_EN
        buf_d     = buf_q;
        buf_n_d   = buf_n_q;
        idle_d    = idle_q;
        issue_buf = 1'b0;
        buf_src   = buf_q;
        buf_cnt   = buf_n_q;
        buf_ins   = buf_q | ({pix_data, 104'h0} >> {buf_n_q, 4'b0000});
`endif
        case (state_q)
            ST_OFF: begin
                if (start) begin
                    state_d   = ST_PWR_WAIT;
                    tmr_load  = 1'b1;
                    tmr_value = TMR_W'(PWR_WAIT_CYC - 1);
                end
            end
            ST_PWR_WAIT: begin
                if (tmr_expired) begin
                    state_d   = ST_RES_LOW;
                    tmr_load  = 1'b1;
                    tmr_value = TMR_W'(RES_LOW_CYC - 1);
                end
            end
            ST_RES_LOW: begin
                if (tmr_expired) begin
                    state_d   = ST_RES_HIGH;
                    tmr_load  = 1'b1;
                    tmr_value = TMR_W'(RES_LOW_CYC - 1);
                end
            end
            ST_RES_HIGH: begin
                if (tmr_expired) begin
                    state_d = ST_INIT;
                end
            end
            ST_INIT: begin
                xfer_type_d  = 1'b0;
                xfer_cnt_d   = init_ent.count;
                xfer_bytes_d = init_ent.bytes;
                from_cmd_d   = 1'b0;
                init_idx_d   = init_idx_q + 1'b1;
                state_d      = ST_ISSUE;
            end
            ST_VCC_WAIT: begin
                if (tmr_expired) begin
                    state_d = ST_DISP_ON;
                end
            end
            ST_DISP_ON: begin
                xfer_type_d  = 1'b0;
                xfer_cnt_d   = 4'd1;
                xfer_bytes_d = {CMD_DISPLAY_ON, 112'h0};
                from_cmd_d   = 1'b0;
                init_idx_d   = init_idx_q + 1'b1;
                state_d      = ST_ISSUE;
            end
            ST_READY: begin
`ifdef OLED_PIX_BATCH_EN
                // A pending command first drains any buffered pixels.
                if (cmd_req && (buf_n_q != 3'd0)) begin
                    issue_buf = 1'b1;
                end else if (cmd_req) begin
                    xfer_type_d  = 1'b0;
                    xfer_cnt_d   = cmd_count;
                    xfer_bytes_d = cmd_bytes;
                    from_cmd_d   = 1'b1;
                    state_d      = ST_ISSUE;
                end else if (pix_accept) begin
                    if ((buf_n_q == 3'(PIX_PER_BATCH - 1)) || pix_last) begin
                        issue_buf = 1'b1;
                        buf_src   = buf_ins;
                        buf_cnt   = buf_n_q + 1'b1;
                    end else begin
                        buf_d   = buf_ins;
                        buf_n_d = buf_n_q + 1'b1;
                        idle_d  = '0;
                    end
                end else if (buf_n_q != 3'd0) begin
                    if (idle_q == IDLE_W'(FLUSH_CYC - 1)) begin
                        issue_buf = 1'b1;
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
                end
`else
                if (cmd_req) begin
                    xfer_type_d  = 1'b0;
                    xfer_cnt_d   = cmd_count;
                    xfer_bytes_d = cmd_bytes;
                    from_cmd_d   = 1'b1;
                    state_d      = ST_ISSUE;
                end else if (pix_accept) begin
                    xfer_type_d  = 1'b1;
                    xfer_cnt_d   = 4'd2;
                    xfer_bytes_d = {pix_data, 104'h0};
                    from_cmd_d   = 1'b0;
                    state_d      = ST_ISSUE;
                end
`endif
            end
            ST_ISSUE: begin
                state_d = (xfer_cnt_q == 4'd0) ? ST_READY : ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                // The init index also tracks where power-up resumes after each transfer.
                if (spi_done) begin
                    if (ready_q) begin
                        state_d = ST_READY;
                    end else if (init_idx_q < INIT_IDX_W'(INIT_LEN)) begin
                        state_d = ST_INIT;
                    end else if (init_idx_q == INIT_IDX_W'(INIT_LEN)) begin
                        state_d   = ST_VCC_WAIT;
                        tmr_load  = 1'b1;
                        tmr_value = TMR_W'(VCC_WAIT_CYC - 1);
                    end else begin
                        state_d = ST_READY;
                    end
                end
            end
            default: state_d = ST_OFF;
        endcase
`ifdef OLED_PIX_BATCH_EN
        if (issue_buf) begin
            xfer_type_d  = 1'b1;
            xfer_cnt_d   = {buf_cnt, 1'b0};
            xfer_bytes_d = buf_src;
            from_cmd_d   = 1'b0;
            buf_d        = '0;
            buf_n_d      = 3'd0;
            idle_d       = '0;
            state_d      = ST_ISSUE;
        end
`endif
        ready_d = ready_q | (state_d == ST_READY);
    end

    always_comb begin
        spi_byte_count = (state_q == ST_ISSUE) ? xfer_cnt_q : 4'd0;
        spi_bytes      = xfer_bytes_q;
        spi_data_type  = xfer_type_q;
        cmd_ack        = (state_q == ST_ISSUE) && from_cmd_q;
        pix_ready      = (state_q == ST_READY) && !cmd_req;
        oled_pmoden    = (state_q != ST_OFF);
        oled_res       = (state_q != ST_RES_LOW);
        oled_vccen     = (state_q == ST_VCC_WAIT) || (state_q == ST_DISP_ON) ||
                         (init_idx_q == INIT_IDX_W'(INIT_LEN + 1));
        ready          = ready_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_oled_seq_ctrl.sv
// ============================================================================
//  Module   : tb_oled_seq_ctrl
//  Brief    : Scoreboard bench for oled_seq_ctrl with a 10-cycle SPI engine model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_oled_seq_ctrl;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         cmd_req;
    logic [3:0]   cmd_count;
    logic [119:0] cmd_bytes;
    logic         cmd_ack;
    logic         pix_valid;
    logic [15:0]  pix_data;
    logic         pix_last;
    logic         pix_ready;
    logic         spi_data_type;
    logic [3:0]   spi_byte_count;
    logic [119:0] spi_bytes;
    logic         spi_done;
    logic         oled_pmoden;
    logic         oled_vccen;
    logic         oled_res;
    logic         ready;

    typedef logic [124:0] xfer_t;
    xfer_t exp_q[$];

    int   n_tests;
    int   n_fail;
    int   ack_cnt;
    int   strobe_cnt;
    logic busy;
    logic alive;
    logic prev_strobe;

    oled_seq_ctrl #(
        .PWR_WAIT_CYC (20),
        .RES_LOW_CYC  (5),
        .VCC_WAIT_CYC (30),
        .FLUSH_CYC    (64)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .cmd_req        (cmd_req),
        .cmd_count      (cmd_count),
        .cmd_bytes      (cmd_bytes),
        .cmd_ack        (cmd_ack),
        .pix_valid      (pix_valid),
        .pix_data       (pix_data),
        .pix_last       (pix_last),
        .pix_ready      (pix_ready),
        .spi_data_type  (spi_data_type),
        .spi_byte_count (spi_byte_count),
        .spi_bytes      (spi_bytes),
        .spi_done       (spi_done),
        .oled_pmoden    (oled_pmoden),
        .oled_vccen     (oled_vccen),
        .oled_res       (oled_res),
        .ready          (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset();
        check("rst_count", 128'(spi_byte_count), 128'd0);
        check("rst_bytes", 128'(spi_bytes), 128'd0);
        check("rst_ctrl", 128'({spi_data_type, cmd_ack, pix_ready, ready,
                                oled_pmoden, oled_vccen, oled_res}), 128'(7'b0000001));
    endtask

    // SPI engine model: done pulse ten cycles after the issue strobe.
    initial begin
        spi_done = 1'b0;
        busy     = 1'b0;
        alive    = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && (spi_byte_count != 4'd0)) begin
                busy  = 1'b1;
                alive = 1'b1;
                for (int i = 0; i < 9 && alive; i++) begin
                    @(negedge clk);
                    if (!rst_n) alive = 1'b0;
                end
                if (alive) begin
                    spi_done = 1'b1;
                    @(negedge clk);
                    spi_done = 1'b0;
                end
                busy = 1'b0;
            end
        end
    end

    // Monitor: every issue strobe pops one expected transfer.
    initial begin
        xfer_t e;
        ack_cnt     = 0;
        strobe_cnt  = 0;
        prev_strobe = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_strobe = 1'b0;
            end else begin
                if (cmd_ack) ack_cnt++;
                if (spi_byte_count != 4'd0) begin
                    strobe_cnt++;
                    check("strobe_width", 128'(prev_strobe), 128'd0);
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL xfer_unexpected: got type=%0d count=%0d bytes=0x%h, expected none",
                                 spi_data_type, spi_byte_count, spi_bytes);
                    end else begin
                        e = exp_q.pop_front();
                        check("xfer", 128'({spi_data_type, spi_byte_count, spi_bytes}), 128'(e));
                    end
                    prev_strobe = 1'b1;
                end else begin
                    prev_strobe = 1'b0;
                end
            end
        end
    end

    task automatic wait_idle(input int limit);
        int quiet;
        logic ok;
        quiet = 0;
        ok    = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy && !spi_done) quiet++;
            else quiet = 0;
            if (quiet >= 3) ok = 1'b1;
        end
        check("idle_reached", 128'(ok), 128'd1);
    endtask

    task automatic send_cmd(input logic [3:0] cnt, input logic [119:0] b);
        logic got;
        got = 1'b0;
        @(negedge clk);
        cmd_req   = 1'b1;
        cmd_count = cnt;
        cmd_bytes = b;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (cmd_ack) got = 1'b1;
        end
        cmd_req = 1'b0;
        check("cmd_acked", 128'(got), 128'd1);
    endtask

    task automatic send_pix(input logic [15:0] d, input logic last);
        logic got;
        got = 1'b0;
        @(negedge clk);
        pix_valid = 1'b1;
        pix_data  = d;
        pix_last  = last;
        for (int i = 0; i < 400 && !got; i++) begin
            #1;
            if (pix_ready) got = 1'b1;
            @(negedge clk);
        end
        pix_valid = 1'b0;
        pix_last  = 1'b0;
        check("pix_accepted", 128'(got), 128'd1);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int acks0;
        int strobes0;
        logic [15:0] pv [7];

        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        cmd_req   = 1'b0;
        cmd_count = 4'd0;
        cmd_bytes = '0;
        pix_valid = 1'b0;
        pix_data  = 16'h0;
        pix_last  = 1'b0;

        repeat (3) @(negedge clk);
        check_reset();
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("off_no_start", 128'({oled_pmoden, ready}), 128'd0);

        // Power-up: init ROM then display-on.
        exp_q.push_back({1'b0, 4'd2, 8'hFD, 8'h12, 104'h0});
        exp_q.push_back({1'b0, 4'd1, 8'hAE, 112'h0});
        exp_q.push_back({1'b0, 4'd2, 8'hA0, 8'h72, 104'h0});
        exp_q.push_back({1'b0, 4'd3, 8'h15, 8'h00, 8'h5F, 96'h0});
        exp_q.push_back({1'b0, 4'd1, 8'hAF, 112'h0});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("pwr_first_cycle", 128'({oled_pmoden, oled_res, oled_vccen, ready}), 128'(4'b1100));
        cyc = 0;
        while (oled_res && cyc < 100) begin @(negedge clk); cyc++; end
        check("pwr_wait_cycles", 128'(cyc), 128'd20);
        cyc = 0;
        while (!oled_res && cyc < 100) begin @(negedge clk); cyc++; end
        check("res_low_cycles", 128'(cyc), 128'd5);
        cyc = 0;
        while (!oled_vccen && cyc < 500) begin @(negedge clk); cyc++; end
        check("vccen_rises", 128'(oled_vccen), 128'd1);
        cyc = 0;
        while (spi_byte_count == 4'd0 && cyc < 100) begin @(negedge clk); cyc++; end
        check("vcc_wait_ok", 128'(cyc >= 30 && cyc <= 40), 128'd1);
        wait_idle(500);
        check("powered_up", 128'({ready, oled_vccen, oled_pmoden, oled_res}), 128'(4'b1111));
        check("no_ack_in_init", 128'(ack_cnt), 128'd0);

        // Commands.
        acks0 = ack_cnt;
        exp_q.push_back({1'b0, 4'd3, 8'hAA, 8'hBB, 8'hCC, 96'h0});
        send_cmd(4'd3, {8'hAA, 8'hBB, 8'hCC, 96'h0});
        wait_idle(200);
        check("cmd3_one_ack", 128'(ack_cnt - acks0), 128'd1);

        exp_q.push_back({1'b0, 4'd15, 120'h0102030405060708090A0B0C0D0E0F});
        send_cmd(4'd15, 120'h0102030405060708090A0B0C0D0E0F);
        wait_idle(200);

        // Command and pixel in the same cycle: command wins.
        exp_q.push_back({1'b0, 4'd1, 8'h5A, 112'h0});
        exp_q.push_back({1'b1, 4'd2, 16'hF800, 104'h0});
        fork
            send_cmd(4'd1, {8'h5A, 112'h0});
            send_pix(16'hF800, 1'b0);
        join
        wait_idle(400);

        exp_q.push_back({1'b1, 4'd2, 16'h1234, 104'h0});
        send_pix(16'h1234, 1'b0);
        wait_idle(400);
        exp_q.push_back({1'b1, 4'd2, 16'h07E0, 104'h0});
        send_pix(16'h07E0, 1'b0);
        wait_idle(400);

        // Zero-length command: acknowledged, nothing sent.
        acks0    = ack_cnt;
        strobes0 = strobe_cnt;
        send_cmd(4'd0, {8'hFF, 112'h0});
        repeat (5) @(negedge clk);
        check("cmd0_ack", 128'(ack_cnt - acks0), 128'd1);
        check("cmd0_no_strobe", 128'(strobe_cnt - strobes0), 128'd0);

        // start outside OFF has no effect.
        strobes0 = strobe_cnt;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        check("start_ignored", 128'({ready, oled_pmoden, oled_res, oled_vccen}), 128'(4'b1111));
        check("start_no_strobe", 128'(strobe_cnt - strobes0), 128'd0);

`ifdef OLED_PIX_BATCH_EN
        pv[0] = 16'h1111; pv[1] = 16'h2222; pv[2] = 16'h3333; pv[3] = 16'h4444;
        pv[4] = 16'h5555; pv[5] = 16'h6666; pv[6] = 16'h7777;
        exp_q.push_back({1'b1, 4'd14, 16'h1111, 16'h2222, 16'h3333, 16'h4444,
                         16'h5555, 16'h6666, 16'h7777, 8'h00});
        for (int i = 0; i < 7; i++) send_pix(pv[i], 1'b0);
        wait_idle(200);

        exp_q.push_back({1'b1, 4'd6, 16'hA001, 16'hA002, 16'hA003, 72'h0});
        send_pix(16'hA001, 1'b0);
        send_pix(16'hA002, 1'b0);
        send_pix(16'hA003, 1'b1);
        wait_idle(200);

        exp_q.push_back({1'b1, 4'd4, 16'hB001, 16'hB002, 88'h0});
        send_pix(16'hB001, 1'b0);
        send_pix(16'hB002, 1'b0);
        cyc = 0;
        while (spi_byte_count == 4'd0 && cyc < 200) begin @(negedge clk); cyc++; end
        check("flush_latency", 128'(cyc >= 62 && cyc <= 66), 128'd1);
        wait_idle(200);

        exp_q.push_back({1'b1, 4'd4, 16'hC001, 16'hC002, 88'h0});
        exp_q.push_back({1'b0, 4'd2, 8'hDE, 8'hAD, 104'h0});
        send_pix(16'hC001, 1'b0);
        send_pix(16'hC002, 1'b0);
        send_cmd(4'd2, {8'hDE, 8'hAD, 104'h0});
        wait_idle(200);
`else
        pv[0] = 16'h0;
        check("pix_ready_idle", 128'({pix_ready, pv[0]}), 128'(17'h10000));
`endif

        // Reset while a transfer is outstanding.
        exp_q.push_back({1'b0, 4'd2, 8'h3C, 8'h4B, 104'h0});
        send_cmd(4'd2, {8'h3C, 8'h4B, 104'h0});
        repeat (3) @(negedge clk);
        check("in_flight", 128'({busy, spi_byte_count}), 128'(5'b10000));
        rst_n = 1'b0;
        #1;
        check_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check("off_after_reset", 128'({oled_pmoden, ready, oled_vccen, spi_byte_count}), 128'd0);
        check("scoreboard_drained", 128'(exp_q.size()), 128'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
